// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage_pkg : fetch FSM state encoding and IF/ID bubble values  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package fetch_stage_pkg;

    typedef enum logic [1:0] {
        FS_IDLE   = 2'b00,
        FS_RUN    = 2'b01,
        FS_HALTED = 2'b10
    } fetch_state_e;

    localparam logic [1:0] C_ST_IDLE   = FS_IDLE;
    localparam logic [1:0] C_ST_RUN    = FS_RUN;
    localparam logic [1:0] C_ST_HALTED = FS_HALTED;

    // Bubble fields are all zero; sliced to the instantiated widths.
    localparam int              C_MAX_WIDTH    = 64;
    localparam logic [C_MAX_WIDTH-1:0] C_BUBBLE_WORD = '0;
    localparam logic            C_BUBBLE_VALID = 1'b0;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage_if : control, instruction-memory and IF/ID signals     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface fetch_stage_if #(
    parameter int PCWIDTH     = 16,
    parameter int INSTRWIDTH  = 24,
    parameter int OPCODEWIDTH = 4
);
    logic                   startF;
    logic                   haltF;
    logic                   stallF;
    logic                   stallD;
    logic                   flushD;
    logic                   branchTakenE;
    logic [PCWIDTH-1:0]     branchTargetE;
    logic [PCWIDTH-1:0]     instrAddrF;
    logic [INSTRWIDTH-1:0]  instrDataF;
    logic [INSTRWIDTH-1:0]  instrD;
    logic [PCWIDTH-1:0]     pcD;
    logic [OPCODEWIDTH-1:0] opcodeD;
    logic                   validD;
    logic [15:0]            fetchCount;
    logic [1:0]             stateF;

    // Fetch-stage side: drives the memory address and the IF/ID outputs.
    modport master (
        input  startF, haltF, stallF, stallD, flushD,
        input  branchTakenE, branchTargetE, instrDataF,
        output instrAddrF, instrD, pcD, opcodeD, validD, fetchCount, stateF
    );

    modport slave (
        output startF, haltF, stallF, stallD, flushD,
        output branchTakenE, branchTargetE, instrDataF,
        input  instrAddrF, instrD, pcD, opcodeD, validD, fetchCount, stateF
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage_if_id_register.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | if_id_register : IF/ID pipeline register with flush and stall      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module if_id_register
    import fetch_stage_pkg::*;
#(
    parameter int PCWIDTH    = 16,
    parameter int INSTRWIDTH = 24
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_flush,
    input  wire logic                  i_stall,
    input  wire logic                  i_load,
    input  wire logic [INSTRWIDTH-1:0] i_instr,
    input  wire logic [PCWIDTH-1:0]    i_pc,
    output logic      [INSTRWIDTH-1:0] o_instr,
    output logic      [PCWIDTH-1:0]    o_pc,
    output logic                       o_valid
);

    logic [INSTRWIDTH-1:0] instr_q, instr_d;
    logic [PCWIDTH-1:0]    pc_q, pc_d;
    logic                  valid_q, valid_d;

    // Flush beats stall; an unloaded, unstalled cycle also inserts a bubble.
    always_comb begin
        instr_d = C_BUBBLE_WORD[INSTRWIDTH-1:0];
        pc_d    = C_BUBBLE_WORD[PCWIDTH-1:0];
        valid_d = C_BUBBLE_VALID;
        if (i_flush) begin
            instr_d = C_BUBBLE_WORD[INSTRWIDTH-1:0];
        end else if (i_stall) begin
            instr_d = instr_q;
            pc_d    = pc_q;
            valid_d = valid_q;
        end else if (i_load) begin
            instr_d = i_instr;
            pc_d    = i_pc;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_q <= C_BUBBLE_WORD[INSTRWIDTH-1:0];
            pc_q    <= C_BUBBLE_WORD[PCWIDTH-1:0];
            valid_q <= C_BUBBLE_VALID;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign o_instr = instr_q;
    assign o_pc    = pc_q;
    assign o_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fetch_stage : PC register, fetch FSM and IF/ID register            |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int PCWIDTH     = 16,
    parameter int INSTRWIDTH  = 24,
    parameter int OPCODEWIDTH = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    fetch_stage_if.master bus
);

    logic [1:0]            state_q, state_d;
    logic [PCWIDTH-1:0]    pc_q, pc_d;
    logic [15:0]           fetch_count_q, fetch_count_d;
    logic                  w_run;
    logic                  w_flush;
    logic                  w_load_valid;
    logic [INSTRWIDTH-1:0] w_instr;

    always_comb begin
        w_run        = (state_q == C_ST_RUN);
        w_flush      = bus.branchTakenE | bus.flushD;
        w_load_valid = w_run & ~w_flush & ~bus.stallD;
    end

    // haltF wins over startF in every state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            C_ST_IDLE:   if (bus.startF && !bus.haltF) state_d = C_ST_RUN;
            C_ST_RUN:    if (bus.haltF)                state_d = C_ST_HALTED;
            C_ST_HALTED: if (bus.startF && !bus.haltF) state_d = C_ST_RUN;
            default:                                   state_d = C_ST_IDLE;
        endcase
    end

    // A redirect updates the PC even while idle or halted.
    always_comb begin
        pc_d = pc_q;
        if (bus.branchTakenE) begin
            pc_d = bus.branchTargetE;
        end else if (w_run && !bus.stallF) begin
            pc_d = pc_q + PCWIDTH'(1);
        end
    end

    always_comb begin
        fetch_count_d = fetch_count_q;
        if (w_load_valid && (fetch_count_q != 16'hFFFF)) begin
            fetch_count_d = fetch_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= C_ST_IDLE;
            pc_q          <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    if_id_register #(
        .PCWIDTH    (PCWIDTH),
        .INSTRWIDTH (INSTRWIDTH)
    ) u_if_id (
        .clk     (clk),
        .rst     (reset),
        .i_flush (w_flush),
        .i_stall (bus.stallD),
        .i_load  (w_run),
        .i_instr (bus.instrDataF),
        .i_pc    (pc_q),
        .o_instr (w_instr),
        .o_pc    (bus.pcD),
        .o_valid (bus.validD)
    );

    assign bus.instrAddrF = pc_q;
    assign bus.instrD     = w_instr;
    assign bus.opcodeD    = w_instr[INSTRWIDTH-1 -: OPCODEWIDTH];
    assign bus.fetchCount = fetch_count_q;
    assign bus.stateF     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_fetch_stage : scoreboard bench with a cycle-level reference     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam int PCW = 16;
    localparam int IW  = 24;
    localparam int OW  = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if #(.PCWIDTH(PCW), .INSTRWIDTH(IW), .OPCODEWIDTH(OW)) bus ();

    fetch_stage #(.PCWIDTH(PCW), .INSTRWIDTH(IW), .OPCODEWIDTH(OW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    int mem_mode = 0;

    function automatic logic [IW-1:0] mem_f(input logic [PCW-1:0] a, input int mode);
        if (mode == 0) return {8'h00, a} + 24'h000010;
        return {a[7:0] ^ 8'hA5, a};
    endfunction

    always_comb bus.instrDataF = mem_f(bus.instrAddrF, mem_mode);

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference state: 0 idle, 1 run, 2 halted.
    int m_state, m_pc, m_instr, m_pcd, m_valid, m_count;

    typedef struct {
        int state; int pc; int instr; int pcd; int valid; int count;
    } exp_t;
    exp_t sb[$];

    task automatic model_reset();
        m_state = 0; m_pc = 0; m_instr = 0; m_pcd = 0; m_valid = 0; m_count = 0;
        sb.delete();
    endtask

    // Called at a negedge: drive one cycle of inputs, predict, wait for next negedge.
    task automatic step(input bit st, input bit hl, input bit sf, input bit sd,
                        input bit fl, input bit br, input int tgt);
        int fetched;
        bus.startF = st; bus.haltF = hl; bus.stallF = sf; bus.stallD = sd;
        bus.flushD = fl; bus.branchTakenE = br; bus.branchTargetE = tgt[15:0];
        fetched = int'(mem_f(m_pc[15:0], mem_mode));
        if (br || fl) begin
            m_instr = 0; m_pcd = 0; m_valid = 0;
        end else if (sd) begin
            m_instr = m_instr;
        end else if (m_state == 1) begin
            m_instr = fetched; m_pcd = m_pc; m_valid = 1;
            if (m_count < 65535) m_count = m_count + 1;
        end else begin
            m_instr = 0; m_pcd = 0; m_valid = 0;
        end
        if (br) m_pc = tgt % 65536;
        else if (m_state == 1 && !sf) m_pc = (m_pc + 1) % 65536;
        if (m_state == 1 && hl) m_state = 2;
        else if (m_state != 1 && st && !hl) m_state = 1;
        sb.push_back('{m_state, m_pc, m_instr, m_pcd, m_valid, m_count});
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.startF = 0; bus.haltF = 0; bus.stallF = 0; bus.stallD = 0;
        bus.flushD = 0; bus.branchTakenE = 0; bus.branchTargetE = '0;
    endtask

    // Monitor: compares the DUT against the oldest prediction after each edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                sb.delete();
            end else if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("stateF",     32'(bus.stateF),     e.state);
                chk("instrAddrF", 32'(bus.instrAddrF), e.pc);
                chk("instrD",     32'(bus.instrD),     e.instr);
                chk("pcD",        32'(bus.pcD),        e.pcd);
                chk("opcodeD",    32'(bus.opcodeD),    (e.instr >> (IW - OW)) & ((1 << OW) - 1));
                chk("validD",     32'(bus.validD),     e.valid);
                chk("fetchCount", 32'(bus.fetchCount), e.count);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_state"}, 32'(bus.stateF),     0);
        chk({tag, "_addr"},  32'(bus.instrAddrF), 0);
        chk({tag, "_instr"}, 32'(bus.instrD),     0);
        chk({tag, "_pcD"},   32'(bus.pcD),        0);
        chk({tag, "_valid"}, 32'(bus.validD),     0);
        chk({tag, "_count"}, 32'(bus.fetchCount), 0);
    endtask

    initial begin : stimulus
        int hold_count;
        idle_inputs();
        model_reset();
        #2 reset = 1'b1;
        #1 check_reset_outputs("por");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Sequential fetch from 0 with memory returning A+0x10.
        step(1, 0, 0, 0, 0, 0, 0);
        chk("start_addr", 32'(bus.instrAddrF), 0);
        chk("start_valid", 32'(bus.validD), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("seq_addr1", 32'(bus.instrAddrF), 1);
        chk("seq_instr0", 32'(bus.instrD), 32'h10);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("seq_instr1", 32'(bus.instrD), 32'h11);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("seq_addr3", 32'(bus.instrAddrF), 3);
        chk("seq_count3", 32'(bus.fetchCount), 3);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        // Branch at PC 5.
        step(0, 0, 0, 0, 0, 1, 32'h40);
        chk("br_addr", 32'(bus.instrAddrF), 32'h40);
        chk("br_valid", 32'(bus.validD), 0);
        chk("br_instr", 32'(bus.instrD), 0);

        // Double stall at PC 7.
        step(0, 0, 0, 0, 0, 1, 6);
        step(0, 0, 0, 0, 0, 0, 0);
        hold_count = m_count;
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1, 1, 0, 0, 0);
            chk("stall_addr", 32'(bus.instrAddrF), 7);
            chk("stall_instr", 32'(bus.instrD), 32'h16);
            chk("stall_count", 32'(bus.fetchCount), hold_count);
        end

        // Branch beats stallD.
        step(0, 0, 0, 1, 0, 1, 32'h100);
        chk("brstall_addr", 32'(bus.instrAddrF), 32'h100);
        chk("brstall_valid", 32'(bus.validD), 0);

        // PC wrap at 0xFFFF.
        step(0, 0, 0, 0, 0, 1, 32'hFFFF);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("wrap_addr", 32'(bus.instrAddrF), 0);
        chk("wrap_pcD", 32'(bus.pcD), 32'hFFFF);

        // stallF alone reloads the held-PC instruction.
        step(0, 0, 1, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        chk("stallF_instr", 32'(bus.instrD), 32'h10);
        chk("stallF_valid", 32'(bus.validD), 1);

        // Halt at PC 9 then asynchronous reset mid-cycle.
        step(0, 0, 0, 0, 0, 1, 9);
        step(0, 1, 0, 0, 0, 0, 0);
        chk("halt_state", 32'(bus.stateF), 2);
        chk("halt_instr", 32'(bus.instrD), 32'h19);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("halt_bubble", 32'(bus.validD), 0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        model_reset();

        // Randomised control traffic.
        mem_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            int tgt;
            tgt = ($urandom_range(0, 3) == 0) ? 32'hFFFC + $urandom_range(0, 3)
                                               : int'($urandom_range(0, 65535));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, tgt);
        end

        // Reset with a branch and stall pending: both are discarded.
        bus.branchTakenE = 1; bus.branchTargetE = 16'h0077; bus.stallF = 1;
        #2 reset = 1'b1;
        #1 chk("pend_addr", 32'(bus.instrAddrF), 0);
        repeat (2) @(negedge clk);
        idle_inputs();
        reset = 1'b0;
        model_reset();
        mem_mode = 0;
        step(1, 0, 0, 0, 0, 0, 0);
        chk("pend_first_addr", 32'(bus.instrAddrF), 0);
        step(0, 0, 0, 0, 0, 0, 0);
        chk("pend_first_instr", 32'(bus.instrD), 32'h10);

        // Long run to saturate fetchCount.
        for (int i = 0; i < 65600; i++) step(0, 0, 0, 0, 0, 0, 0);
        chk("sat_count", 32'(bus.fetchCount), 32'hFFFF);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PCWIDTH, default 16, width of program counter and instruction-memory address.
REQ-002 Parameter INSTRWIDTH, default 24, instruction word width.
REQ-003 Parameter OPCODEWIDTH, default 4, opcode field width, taken from instruction bits [INSTRWIDTH-1 -: OPCODEWIDTH].
REQ-004 Ports: clk input 1 system clock; reset input 1 asynchronous active-high reset; the block uses one clock only.
REQ-005 startF input 1 leave IDLE/HALTED and begin fetching; haltF input 1 stop fetching after current cycle.
REQ-006 stallF input 1 hold PC; stallD input 1 hold IF/ID register; flushD input 1 load bubble into IF/ID register.
REQ-007 branchTakenE input 1 redirect request from execute; branchTargetE input PCWIDTH redirect address.
REQ-008 instrAddrF output PCWIDTH instruction-memory address (= PC); instrDataF input INSTRWIDTH combinational memory read data for instrAddrF.
REQ-009 instrD output INSTRWIDTH, pcD output PCWIDTH, opcodeD output OPCODEWIDTH, validD output 1: IF/ID register contents feeding the decode control unit.
REQ-010 fetchCount output 16 saturating count of instructions accepted into IF/ID; stateF output 2 current FSM state.

Function
REQ-011 FSM states IDLE, RUN, HALTED; IDLE->RUN on startF; RUN->HALTED on haltF; HALTED->RUN on startF; haltF has priority over startF when both high.
REQ-012 In RUN, PC next-value priority: branchTakenE -> branchTargetE; else stallF -> hold; else PC+1 (modulo 2^PCWIDTH, 16'hFFFF wraps to 0).
REQ-013 In IDLE and HALTED, PC holds except branchTakenE, which still updates PC.
REQ-014 IF/ID next-value priority: branchTakenE or flushD -> bubble; else stallD -> hold all fields; else if RUN -> load instrDataF, PC, validD=1; else bubble.
REQ-015 Bubble = instrD 0, opcodeD 0, pcD 0, validD 0.
REQ-016 opcodeD is always the top OPCODEWIDTH bits of instrD (no separate state).
REQ-017 Latency: instruction at address A appears on instrD one cycle after instrAddrF=A when not stalled or flushed.
REQ-018 fetchCount increments by 1 on each cycle a valid instruction loads into IF/ID; saturates at 16'hFFFF.
REQ-019 Simultaneous branchTakenE and stallF/stallD: branch wins; PC redirects and IF/ID bubbles.
REQ-020 haltF while RUN: the instruction fetched in that cycle still loads into IF/ID; subsequent cycles bubble.
REQ-021 stallF without stallD is legal: IF/ID reloads the same held-PC instruction.

Reset
REQ-022 On reset assertion, asynchronously: state IDLE, PC 0, IF/ID bubble (REQ-015), fetchCount 0.
REQ-023 Reset mid-operation discards any pending branch or stall; first fetch after release occurs at PC 0 in the cycle after startF.
REQ-024 All outputs reach reset values without a clock edge.

Structure
REQ-025 Shared package holds FSM state enum (IDLE=2'b00, RUN=2'b01, HALTED=2'b10) and bubble constant.
REQ-026 One sub-module, if_id_register, holds instrD/pcD/validD with stall and flush inputs; PC register and FSM stay in fetch_stage.

Verification
REQ-027 reset, startF pulse, memory returns A+8'h10 -> instrAddrF 0,1,2,3; instrD 16'h10,16'h11 lagging one cycle; validD 1; fetchCount 3 after 3 loads.
REQ-028 RUN at PC 5, branchTakenE with target 16'h0040 -> next instrAddrF 16'h0040, instrD bubble for one cycle, validD 0.
REQ-029 stallF and stallD high 2 cycles at PC 7 -> instrAddrF stays 7, instrD unchanged, fetchCount unchanged.
REQ-030 stallD with branchTakenE same cycle -> branch target taken, IF/ID bubbled.
REQ-031 PC 16'hFFFF unstalled -> next instrAddrF 0; fetchCount preset near 16'hFFFF via long run -> holds at 16'hFFFF.
REQ-032 haltF at PC 9, reset asserted mid-cycle two cycles later -> state HALTED then IDLE immediately, PC 0, validD 0 without clock edge.
